// File: rtl/softmax_result_writer_pkg.sv
// Shared widths and FSM encoding for the softmax result writer.
package softmax_result_writer_pkg;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_NUM       = 4;
    localparam int DEF_ADDRSIZE  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/softmax_result_writer_wr_fifo.sv
// Two-entry synchronous FIFO between the softmax lanes and the RAM write port.
module softmax_wr_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        // A full FIFO may still take a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            slot_d[wr_ptr_q] = din;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            slot_q   <= slot_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = slot_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/softmax_result_writer.sv
// Packs four softmax lane results per beat and writes them over an inclusive address range.
module softmax_result_writer
    import softmax_result_writer_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM       = DEF_NUM,
    parameter int ADDRSIZE  = DEF_ADDRSIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRSIZE-1:0]      start_addr,
    input  logic [ADDRSIZE-1:0]      end_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATAWIDTH-1:0]     outp0,
    input  logic [DATAWIDTH-1:0]     outp1,
    input  logic [DATAWIDTH-1:0]     outp2,
    input  logic [DATAWIDTH-1:0]     outp3,
    output logic [ADDRSIZE-1:0]      mem_addr,
    output logic [DATAWIDTH*NUM-1:0] mem_d,
    output logic                     mem_we,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int WORD_W = DATAWIDTH * NUM;
    localparam int CNT_W  = ADDRSIZE + 1;

    state_e              state_q, state_d;
    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic                overrun_q, overrun_d;
    logic [1:0]          fifo_count;
    logic [WORD_W-1:0]   fifo_dout;
    logic                push, pop;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        total_d   = total_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        overrun_d = overrun_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                if (start) begin
                    // Modular difference lets the range wrap through address 0.
                    wr_ptr_d  = start_addr;
                    total_d   = {1'b0, end_addr - start_addr} + CNT_W'(1);
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    overrun_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (fifo_count < 2'd2) && (acc_cnt_q < total_q);
                mem_we   = (fifo_count != 2'd0);
                push     = in_valid && in_ready;
                pop      = mem_we && mem_ready;
                if (push) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
                if (pop) begin
                    wr_ptr_d = wr_ptr_q + ADDRSIZE'(1);
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q + CNT_W'(1) == total_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            total_q   <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            total_q   <= total_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    softmax_wr_fifo #(
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  ({outp3, outp2, outp1, outp0}),
        .dout (fifo_dout),
        .count(fifo_count)
    );

    assign mem_addr = wr_ptr_q;
    assign mem_d    = fifo_dout;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_softmax_result_writer.sv
// Directed bench for softmax_result_writer: ranges, backpressure, wrap, errors, abort.
module tb_softmax_result_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [7:0]  end_addr = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] outp0 = 16'h0, outp1 = 16'h0, outp2 = 16'h0, outp3 = 16'h0;
    logic [7:0]  mem_addr;
    logic [63:0] mem_d;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        busy, done, overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    softmax_result_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outp0     (outp0),
        .outp1     (outp1),
        .outp2     (outp2),
        .outp3     (outp3),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Basic vector uses the fixed lane values; other runs tag every lane with the beat index.
    function automatic logic [63:0] word(input int k, input bit cdata);
        logic [15:0] kk;
        kk = 16'(k);
        if (cdata) return 64'h993e_4210_4040_3800;
        return {16'hD000 | kk, 16'hC000 | kk, 16'hB000 | kk, 16'hA000 | kk};
    endfunction

    task automatic run_range(input logic [7:0] sa, input logic [7:0] ea, input int exp_n,
                             input bit bp, input bit cdata, input bit restart, input int abort_after);
        int          sent = 0;
        int          commits = 0;
        int          buffered;
        bit          held = 1'b0;
        bit          saw_done = 1'b0;
        bit          aborted = 1'b0;
        logic [7:0]  h_addr = 8'h00;
        logic [63:0] h_data = 64'h0;
        logic [7:0]  eaddr;
        start = 1'b1; start_addr = sa; end_addr = ea; in_valid = 1'b0; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("overrun_after_start", overrun, 0);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start = restart && (cyc == 1);
            if (start) begin
                start_addr = 8'h50;
                end_addr   = 8'h60;
            end
            in_valid = (sent < exp_n);
            {outp3, outp2, outp1, outp0} = word(sent, cdata);
            mem_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (abort_after >= 0 && commits == abort_after) begin
                reset = 1'b0;
                #1;
                check_eq("abort_mem_we", mem_we, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_mem_addr", mem_addr, 0);
                aborted = 1'b1;
                break;
            end
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            buffered = sent - commits;
            check_eq("busy_run", busy, 1);
            check_eq("in_ready", in_ready, (buffered < 2) && (sent < exp_n));
            check_eq("mem_we", mem_we, buffered > 0);
            if (held) begin
                check_eq("hold_addr", mem_addr, h_addr);
                check_eq("hold_data", mem_d, h_data);
            end
            if (mem_we && mem_ready) begin
                eaddr = sa + 8'(commits);
                check_eq("wr_addr", mem_addr, eaddr);
                check_eq("wr_data", mem_d, word(commits, cdata));
                commits++;
                held = 1'b0;
            end else begin
                held   = mem_we;
                h_addr = mem_addr;
                h_data = mem_d;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (aborted) begin
            tick();
            check_eq("abort_no_done", done, 0);
            reset = 1'b1;
            tick();
            check_eq("abort_idle_busy", busy, 0);
        end else begin
            check_eq("done_seen", saw_done, 1);
            check_eq("commit_count", commits, exp_n);
            check_eq("done_busy", busy, 0);
            check_eq("done_in_ready", in_ready, 0);
            check_eq("done_mem_we", mem_we, 0);
            tick();
            check_eq("done_pulse_len", done, 0);
            check_eq("post_mem_we", mem_we, 0);
            check_eq("post_busy", busy, 0);
            tick();
            check_eq("post2_mem_we", mem_we, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_d", mem_d, 0);
        reset = 1'b1;
        tick();

        run_range(8'h03, 8'h07, 5, 1'b0, 1'b1, 1'b0, -1);
        run_range(8'h03, 8'h07, 5, 1'b1, 1'b0, 1'b0, -1);
        run_range(8'hFE, 8'h01, 4, 1'b0, 1'b0, 1'b0, -1);
        run_range(8'h10, 8'h10, 1, 1'b0, 1'b0, 1'b0, -1);
        run_range(8'h00, 8'hFF, 256, 1'b0, 1'b0, 1'b0, -1);

        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("idle_overrun_set", overrun, 1);
        check_eq("idle_no_write", mem_we, 0);
        tick();
        check_eq("overrun_sticky", overrun, 1);
        run_range(8'h20, 8'h22, 3, 1'b0, 1'b0, 1'b1, -1);

        run_range(8'h03, 8'h07, 5, 1'b0, 1'b0, 1'b0, 2);
        run_range(8'h03, 8'h07, 5, 1'b0, 1'b1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_result_writer.md
Name: softmax_result_writer

Overview:
- Write-side counterpart to the softmax input read ports. Receives the four lane results (outp0..outp3) per beat and packs them into one DATAWIDTH*NUM word.
- Writes each word into the result RAM over an address range [start_addr, end_addr], with end_addr inclusive.
- A 2-entry buffer decouples softmax output from a write port that can stall.
- Signals done when every word of the range has been written.

Parameters:
- DATAWIDTH, 16, bits per lane (matches `DATAWIDTH).
- NUM, 4, lanes per word (matches `NUM).
- ADDRSIZE, 8, RAM address width (matches `ADDRSIZE).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; latches start_addr/end_addr and arms the block.
- start_addr  in  ADDRSIZE  first write address.
- end_addr  in  ADDRSIZE  last write address (inclusive).
- in_valid  in  1  lane results valid this cycle.
- in_ready  out  1  block can accept a beat; a beat transfers when in_valid && in_ready.
- outp0..outp3  in  DATAWIDTH each  lane results; outp0 maps to bits [DATAWIDTH-1:0], outp3 to the MSBs.
- mem_addr  out  ADDRSIZE  write address.
- mem_d  out  DATAWIDTH*NUM  write data.
- mem_we  out  1  write request.
- mem_ready  in  1  write port accepts; a write commits when mem_we && mem_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  1-cycle pulse after the last write commits.
- overrun  out  1  sticky error flag: in_valid seen while not accepting.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, all pointers and counters 0. Outputs in_ready, mem_we, busy, done, overrun = 0; mem_addr, mem_d = 0.
- Word count: total = ((end_addr - start_addr) mod 2^ADDRSIZE) + 1.
  - Range 1..2^ADDRSIZE words.
  - end_addr < start_addr wraps through address 0. Example: start=FE, end=01 gives 4 words at FE, FF, 00, 01.
- State IDLE:
  - in_ready=0, busy=0.
  - start=1: latch wr_ptr=start_addr and total; clear acc_cnt, wr_cnt and overrun; go to RUN.
- State RUN:
  - busy=1.
  - in_ready = (fifo_count < 2) && (acc_cnt < total). This term is registered-state only, with no combinational path from mem_ready.
  - Accepted beat: push {outp3,outp2,outp1,outp0}; acc_cnt++.
  - mem_we = FIFO non-empty; mem_d = FIFO head; mem_addr = wr_ptr.
  - Committed write: pop; wr_ptr = wr_ptr+1 mod 2^ADDRSIZE; wr_cnt++.
  - Commit of the final word (wr_cnt reaches total): go to DONE.
- State DONE:
  - done=1 for exactly one cycle; busy=0; in_ready=0.
  - Next cycle returns to IDLE.
- Latency: a beat accepted in cycle N drives mem_we=1 in cycle N+1. With mem_ready held high, throughput is 1 word/cycle sustained.
- Push and pop in the same cycle: legal at any fill level ≤2. Count is unchanged; data order is preserved.
- mem_ready low: mem_we, mem_addr and mem_d hold stable until commit. The FIFO fills to 2, then in_ready drops.
- start while busy or in DONE: ignored, with no change to latched range or counters.
- in_valid while in_ready=0 outside RUN (i.e., in IDLE or DONE): beat dropped, overrun set to 1. overrun stays set until the next accepted start.
- in_valid in RUN while in_ready=0 is normal backpressure, not an overrun. The producer holds its data.
- Reset asserted mid-operation: immediate abort, all state returns to its reset values, no further writes are issued. Already-committed RAM words are left as written.

Decomposition:
- DATAWIDTH, NUM and ADDRSIZE come from the shared defines.v macros, alongside the state encodings (IDLE, RUN, DONE) as localparams/`defines.
- One sub-module: softmax_wr_fifo, a 2-entry synchronous FIFO of width DATAWIDTH*NUM.
  - Ports: push, pop, din, dout, count, and the same async active-low reset.
- The top level holds the FSM, range latch, acc_cnt/wr_cnt and wr_ptr.

Test Plan:
- Basic range: start_addr=03, end_addr=07, in_valid high 5 cycles with lane values 3800/4040/4210/993e, mem_ready=1. Expect 5 writes at 03..07, mem_d=993e42104040 3800 per word, each write 1 cycle after acceptance, done pulses once, busy falls with done, no 6th write.
- Backpressure: same range, mem_ready toggles 1,0,0,1 repeating. Expect mem_addr/mem_d stable while mem_ready=0, in_ready low once 2 words are buffered, exactly 5 commits in order, no data loss.
- Wrap: start_addr=FE, end_addr=01. Expect writes to FE, FF, 00, 01, then done.
- Single word and full range: start=end=10 gives 1 write at 10 and done. start=00, end=FF gives 256 writes.
- Errors: in_valid=1 in IDLE sets overrun=1 with no write. A later start clears overrun. A second start during RUN leaves the range unchanged.
- Reset mid-run: drive reset=0 after 2 of 5 commits. Expect mem_we=0 and busy=0 immediately, no done pulse. The next start runs cleanly.
